// File: rtl/scan_decoder.sv
// Registered one-hot decoder with auto-scan sequencer; optional blanking gap via SCAN_DEC_BLANK_EN.
// Latency: one cycle from en/mode/in to out/idx/wrap; no backpressure, outputs advance every cycle.
module scan_decoder #(
  parameter int SEL_W = 3,
  parameter int DWELL = 4,
  parameter int DW_W  = 16,
  localparam int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] in,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] idx,
  output logic             wrap
);

`ifdef SCAN_DEC_BLANK_EN
  typedef enum logic [1:0] {OFF = 2'd0, DIRECT = 2'd1, SCAN = 2'd2, BLANK = 2'd3} state_e;
`else
  typedef enum logic [1:0] {OFF = 2'd0, DIRECT = 2'd1, SCAN = 2'd2} state_e;
`endif

  localparam logic [DW_W-1:0]  CNT_LAST = DW_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST = {SEL_W{1'b1}};
  localparam logic [OUT_W-1:0] ONE_HOT0 = {{(OUT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DW_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap_d  = 1'b0;
    out_d   = '0;

    if (!en) begin
      // idx and counter hold; the counter is cleared again on re-enable
      state_d = OFF;
    end else begin
      case (state_q)
        SCAN: begin
          if (!mode) begin
            state_d = DIRECT;
            idx_d   = in;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            idx_d  = idx_q + 1'b1;
            wrap_d = (idx_q == IDX_LAST);
`ifdef SCAN_DEC_BLANK_EN
            state_d = BLANK;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          // OFF, DIRECT and BLANK all re-enter scan from the held idx with a fresh dwell
          cnt_d = '0;
          if (mode) begin
            state_d = SCAN;
          end else begin
            state_d = DIRECT;
            idx_d   = in;
          end
        end
      endcase
    end

    if (state_d == DIRECT || state_d == SCAN) begin
      out_d = ONE_HOT0 << idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: per-cycle model comparison on two configurations plus directed literal checks.
module tb_scan_decoder;

`ifdef SCAN_DEC_BLANK_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif
  localparam int PER0 = 4 + B;
  localparam int PER1 = 1 + B;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en0, mode0;
  logic [2:0] in0;
  logic [7:0] out0;
  logic [2:0] idx0;
  logic       wrap0;
  logic       en1, mode1;
  logic [1:0] in1;
  logic [3:0] out1;
  logic [1:0] idx1;
  logic       wrap1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_decoder #(.SEL_W(3), .DWELL(4), .DW_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en0), .mode(mode0), .in(in0),
    .out(out0), .idx(idx0), .wrap(wrap0)
  );

  scan_decoder #(.SEL_W(2), .DWELL(1), .DW_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .mode(mode1), .in(in1),
    .out(out1), .idx(idx1), .wrap(wrap1)
  );

  // Model: which position is lit, how many cycles it has been shown, and whether we sit in a gap.
  typedef struct packed {
    int   idx;
    int   age;
    logic on;
    logic scan;
    logic blank;
    logic wrap;
  } mst_t;

  mst_t m0 = '0;
  mst_t m1 = '0;

  function automatic mst_t step(mst_t s, logic en, logic mode, int in, int ow, int dw);
    mst_t n;
    n = s;
    n.wrap = 1'b0;
    if (!en) begin
      n.on = 1'b0; n.scan = 1'b0; n.blank = 1'b0;
    end else if (!mode) begin
      n.on = 1'b1; n.scan = 1'b0; n.blank = 1'b0; n.idx = in;
    end else if (!s.on || !s.scan) begin
      n.on = 1'b1; n.scan = 1'b1; n.blank = 1'b0; n.age = 1;
    end else if (s.blank) begin
      n.blank = 1'b0; n.age = 1;
    end else if (s.age == dw) begin
      n.idx   = (s.idx + 1) % ow;
      n.wrap  = (n.idx == 0);
      n.age   = 1;
      n.blank = (B == 1);
    end else begin
      n.age = s.age + 1;
    end
    return n;
  endfunction

  function automatic int exp_out(mst_t s);
    return (s.on && !s.blank) ? (1 << s.idx) : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0 = '0;
      m1 = '0;
    end else begin
      m0 = step(m0, en0, mode0, int'(in0), 8, 4);
      m1 = step(m1, en1, mode1, int'(in1), 4, 1);
    end
  end

  task automatic check(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_u0_out", int'(out0), exp_out(m0));
    check("model_u0_idx", int'(idx0), m0.idx);
    check("model_u0_wrap", int'(wrap0), int'(m0.wrap));
    check("model_u1_out", int'(out1), exp_out(m1));
    check("model_u1_idx", int'(idx1), m1.idx);
    check("model_u1_wrap", int'(wrap1), int'(m1.wrap));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ei, eb, ew;
    rst_n = 1'b0;
    en0 = 1'b0; mode0 = 1'b0; in0 = 3'd0;
    en1 = 1'b0; mode1 = 1'b0; in1 = 2'd0;
    tick(2);
    check("rst_out", int'(out0), 0);
    check("rst_idx", int'(idx0), 0);
    check("rst_wrap", int'(wrap0), 0);
    rst_n = 1'b1;
    tick(2);
    check("off_out", int'(out0), 0);

    // Direct decode, one select per cycle
    en0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in0 = 3'(i);
      tick(1);
      check("direct_out", int'(out0), 1 << i);
      check("direct_idx", int'(idx0), i);
    end
    in0 = 3'd0;
    tick(1);

    // Scan from idx 0 until the terminal cycle of idx 6 in the second sweep
    mode0 = 1'b1;
    for (int c = 0; c <= 15 * PER0 - 1 - B; c++) begin
      tick(1);
      ei = ((c + B) / PER0) % 8;
      eb = (B == 1 && (c % PER0) == PER0 - 1) ? 1 : 0;
      ew = (c == 8 * PER0 - B) ? 1 : 0;
      check("scan_idx", int'(idx0), ei);
      check("scan_out", int'(out0), (eb == 1) ? 0 : (1 << ei));
      check("scan_wrap", int'(wrap0), ew);
    end

    // Mode change on the terminal count wins over the advance
    mode0 = 1'b0; in0 = 3'd2;
    tick(1);
    check("modechg_out", int'(out0), 4);
    check("modechg_idx", int'(idx0), 2);

    // Drop enable at idx 3 mid-dwell, then resume with a full dwell
    in0 = 3'd3;
    tick(1);
    mode0 = 1'b1;
    tick(2);
    en0 = 1'b0;
    tick(1);
    check("pause_out", int'(out0), 0);
    check("pause_idx", int'(idx0), 3);
    tick(2);
    en0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(1);
      check("resume_idx", int'(idx0), 3);
      check("resume_out", int'(out0), 8);
    end
    tick(1);
    check("resume_adv_idx", int'(idx0), 4);

    // Asynchronous reset while scanning at idx 5
    tick(4 + B);
    check("prereset_idx", int'(idx0), 5);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out", int'(out0), 0);
    check("async_rst_idx", int'(idx0), 0);
    check("async_rst_wrap", int'(wrap0), 0);
    @(negedge clk);
    en0 = 1'b0;
    rst_n = 1'b1;
    tick(3);
    check("post_rst_out", int'(out0), 0);
    check("post_rst_idx", int'(idx0), 0);

    // Boundary: SEL_W=2, DWELL=1
    en1 = 1'b1; mode1 = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      ei = ((c + B) / PER1) % 4;
      eb = (B == 1 && (c % PER1) == PER1 - 1) ? 1 : 0;
      ew = (c > 0 && ((c + B) % (4 * PER1)) == 0) ? 1 : 0;
      check("fast_idx", int'(idx1), ei);
      check("fast_out", int'(out1), (eb == 1) ? 0 : (1 << ei));
      check("fast_wrap", int'(wrap1), ew);
    end
    en1 = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
